// File: rtl/cache_arbiter_pkg.sv
// Shared CPU bus definitions: data-cache widths, arbiter state encoding,
// grant identity and the buffered memory request.
package cache_arbiter_pkg;

  localparam int DCACHE_ADDR_W  = 32;
  localparam int DCACHE_DATA_W  = 32;
  localparam int DCACHE_WSTRB_W = 4;

  localparam int CPU_ADDR_W = DCACHE_ADDR_W;
  localparam int CPU_DATA_W = DCACHE_DATA_W;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_ADDR = 3'd1,
    ARB_D_DATA = 3'd2,
    ARB_I_ADDR = 3'd3,
    ARB_I_DATA = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0]     addr;
    logic [CPU_DATA_W-1:0]     wdata;
    logic [DCACHE_WSTRB_W-1:0] wen;
  } req_buf_t;

  localparam req_buf_t REQ_BUF_CLEAR = '{addr: 32'd0, wdata: 32'd0, wen: 4'd0};

  // Data wins a tie unless it also won the last completed transaction.
  function automatic grant_e pick_grant(input logic inst_req,
                                        input logic data_req,
                                        input grant_e last_grant);
    grant_e g;
    if (data_req && (!inst_req || (last_grant == GRANT_INST))) begin
      g = GRANT_DATA;
    end else begin
      g = GRANT_INST;
    end
    return g;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the cache arbiter.
// slave: the arbiter's view; master: the caches/memory (or bench) view.
interface cache_arbiter_if;
  import cache_arbiter_pkg::*;

  logic                      inst_cache_req;
  logic [CPU_ADDR_W-1:0]     inst_cache_addr;
  logic [CPU_DATA_W-1:0]     inst_cache_rdata;
  logic                      inst_cache_iok;

  logic                      data_cache_req;
  logic [DCACHE_WSTRB_W-1:0] data_cache_wen;
  logic [CPU_ADDR_W-1:0]     data_cache_addr;
  logic [CPU_DATA_W-1:0]     data_cache_wdata;
  logic [CPU_DATA_W-1:0]     data_cache_rdata;
  logic                      data_cache_dok;

  logic                      mem_req;
  logic                      mem_wr;
  logic [DCACHE_WSTRB_W-1:0] mem_wstrb;
  logic [CPU_ADDR_W-1:0]     mem_addr;
  logic [CPU_DATA_W-1:0]     mem_wdata;
  logic                      mem_addr_ok;
  logic                      mem_data_ok;
  logic [CPU_DATA_W-1:0]     mem_rdata;

  modport slave (
    input  inst_cache_req, inst_cache_addr,
    output inst_cache_rdata, inst_cache_iok,
    input  data_cache_req, data_cache_wen, data_cache_addr, data_cache_wdata,
    output data_cache_rdata, data_cache_dok,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_cache_req, inst_cache_addr,
    input  inst_cache_rdata, inst_cache_iok,
    output data_cache_req, data_cache_wen, data_cache_addr, data_cache_wdata,
    input  data_cache_rdata, data_cache_dok,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates single-word I-cache and D-cache requests onto one memory port,
// one outstanding transaction at a time, alternating grants on contention.
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  grant_e     r_last_grant;
  grant_e     w_grant;
  req_buf_t   r_req_buf;
  req_buf_t   w_req_new;
  logic       w_any_req;
  logic       w_done;
  logic       w_data_txn;
  logic       w_addr_phase;
  logic       w_d_window;
  logic       w_i_window;

  assign w_any_req    = bus.inst_cache_req | bus.data_cache_req;
  assign w_grant      = pick_grant(bus.inst_cache_req, bus.data_cache_req, r_last_grant);
  assign w_data_txn   = (r_state == ARB_D_ADDR) || (r_state == ARB_D_DATA);
  assign w_addr_phase = (r_state == ARB_D_ADDR) || (r_state == ARB_I_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; w_done marks the cycle a transaction completes
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          if (w_grant == GRANT_DATA) begin
            w_next_state = ARB_D_ADDR;
          end else begin
            w_next_state = ARB_I_ADDR;
          end
        end else begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_D_ADDR, ARB_I_ADDR: begin
        if (bus.mem_addr_ok && bus.mem_data_ok) begin
          w_next_state = ARB_IDLE;
          w_done       = 1'b1;
        end else if (bus.mem_addr_ok) begin
          w_next_state = w_data_txn ? ARB_D_DATA : ARB_I_DATA;
        end else begin
          w_next_state = r_state;
        end
      end
      ARB_D_DATA, ARB_I_DATA: begin
        if (bus.mem_data_ok) begin
          w_next_state = ARB_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Payload of the requester about to be granted; instruction fetches never write
  always_comb begin
    w_req_new = REQ_BUF_CLEAR;
    if (w_grant == GRANT_DATA) begin
      w_req_new.addr  = bus.data_cache_addr;
      w_req_new.wdata = bus.data_cache_wdata;
      w_req_new.wen   = bus.data_cache_wen;
    end else begin
      w_req_new.addr  = bus.inst_cache_addr;
      w_req_new.wdata = 32'd0;
      w_req_new.wen   = 4'd0;
    end
  end

  // Request buffer, loaded only on a grant from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_buf <= REQ_BUF_CLEAR;
    end else if ((r_state == ARB_IDLE) && w_any_req) begin
      r_req_buf <= w_req_new;
    end else begin
      r_req_buf <= r_req_buf;
    end
  end

  // Owner of the last completed transaction; abandoned transactions do not count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_INST;
    end else if (w_done) begin
      r_last_grant <= w_data_txn ? GRANT_DATA : GRANT_INST;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // A completion counts in the address phase only when accepted in the same cycle
  assign w_d_window = ((r_state == ARB_D_ADDR) && bus.mem_addr_ok) || (r_state == ARB_D_DATA);
  assign w_i_window = ((r_state == ARB_I_ADDR) && bus.mem_addr_ok) || (r_state == ARB_I_DATA);

  assign bus.data_cache_dok   = ~rst & bus.mem_data_ok & w_d_window;
  assign bus.inst_cache_iok   = ~rst & bus.mem_data_ok & w_i_window;
  assign bus.data_cache_rdata = bus.mem_rdata;
  assign bus.inst_cache_rdata = bus.mem_rdata;

  assign bus.mem_req   = ~rst & w_addr_phase;
  assign bus.mem_wr    = ~rst & (|r_req_buf.wen);
  assign bus.mem_wstrb = r_req_buf.wen;
  assign bus.mem_addr  = r_req_buf.addr;
  assign bus.mem_wdata = r_req_buf.wdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have: inst_cache_req  in  1  instruction-cache single-word read request, held high until inst_cache_iok.
REQ-004 SHALL have: inst_cache_addr  in  32  instruction read address, stable while inst_cache_req is high.
REQ-005 SHALL have: inst_cache_rdata  out  32  instruction read data, valid when inst_cache_iok is high.
REQ-006 SHALL have: inst_cache_iok  out  1  one-cycle completion pulse to the instruction cache.
REQ-007 SHALL have: data_cache_req  in  1  data-cache single-word request, held high until data_cache_dok.
REQ-008 SHALL have: data_cache_wen  in  4  byte write strobes; 0 means read, nonzero means write.
REQ-009 SHALL have: data_cache_addr  in  32  data access address, stable while data_cache_req is high.
REQ-010 SHALL have: data_cache_wdata  in  32  write data, stable while data_cache_req is high.
REQ-011 SHALL have: data_cache_rdata  out  32  read data, valid when data_cache_dok is high.
REQ-012 SHALL have: data_cache_dok  out  1  one-cycle completion pulse to the data cache (reads and writes).
REQ-013 SHALL have: mem_req, mem_wr  out  1 each  memory request and write flag.
REQ-014 SHALL have: mem_wstrb  out  4, mem_addr  out  32, mem_wdata  out  32  memory request payload.
REQ-015 SHALL have: mem_addr_ok  in  1, mem_data_ok  in  1, mem_rdata  in  32  memory address-accept pulse, completion pulse and read data.

Function
REQ-016 SHALL implement the FSM states IDLE, D_ADDR, D_DATA, I_ADDR and I_DATA.
REQ-017 In IDLE with only data_cache_req high, SHALL go to D_ADDR; with only inst_cache_req high, SHALL go to I_ADDR.
REQ-018 In IDLE with both requests high, SHALL grant data, unless the last completed grant was data, in which case SHALL grant inst (no starvation).
REQ-019 On grant, SHALL register addr, wdata, wen (inst: wen=0) into a request buffer; mem_addr/mem_wdata/mem_wstrb SHALL drive from that buffer only.
REQ-020 mem_req SHALL be high exactly in D_ADDR and I_ADDR; mem_wr = |buffered wen; mem_wstrb = buffered wen.
REQ-021 In x_ADDR, SHALL hold the request stable until mem_addr_ok, then go to x_DATA; if mem_addr_ok and mem_data_ok are high in the same cycle, SHALL complete directly and go to IDLE.
REQ-022 In x_DATA, SHALL wait for mem_data_ok, then go to IDLE; in IDLE, mem_data_ok SHALL be ignored.
REQ-023 data_cache_dok SHALL be mem_data_ok gated by a data transaction in its address-accept or data state (combinational, same cycle); inst_cache_iok likewise for inst.
REQ-024 inst_cache_rdata and data_cache_rdata SHALL be mem_rdata passed through; only the matching ok qualifies them.
REQ-025 Latency, zero-wait memory: request high at cycle 0 -> mem_req at cycle 1 -> earliest ok at cycle 1 (combined acceptance) or cycle 2.
REQ-026 A requester that keeps req high after its ok (dirty writeback followed by line load) SHALL be treated as a new request in the following IDLE cycle, re-sampling addr, wen and wdata.
REQ-027 Only one memory transaction SHALL be outstanding; an ok SHALL never be issued to the non-granted requester.

Reset
REQ-028 While rst is high, SHALL enter IDLE, set last-grant=inst, clear the request buffer, and drive mem_req, mem_wr, inst_cache_iok and data_cache_dok to 0.
REQ-029 A reset mid-transaction SHALL abandon that transaction; a late mem_data_ok after reset SHALL produce no ok.

Structure
REQ-030 State encodings and the 32-bit address/data widths SHALL live in the shared cpu defines package next to the DCACHE_* widths.
REQ-031 The module SHALL be flat; no sub-module is needed.

Verification
REQ-032 Data read 0x0000_1000, memory addr_ok at cycle 1, data_ok at cycle 3 with 0xDEADBEEF -> data_cache_dok for one cycle at cycle 3 with data_cache_rdata=0xDEADBEEF; mem_wr=0.
REQ-033 Simultaneous inst 0xBFC0_0000 and data write 0x1FAF_F000 wen=0xF, issued back-to-back twice -> order is D, I, D, I, and each ok goes only to its owner.
REQ-034 Writeback then load: data req held high, wen=0xF addr 0x0000_2000, then wen=0 addr 0x0000_4000 after dok -> two mem transactions with the correct mem_wr/addr each.
REQ-035 addr_ok and data_ok in the same cycle -> FSM returns to IDLE and a single ok is issued.
REQ-036 rst asserted in D_DATA, then mem_data_ok one cycle later -> no dok, mem_req=0, and the FSM is in IDLE.
